// File: rtl/add_wrap_tagq.sv
// add_wrap_tagq
// Wrapper around a pipelined, variable-latency add/sub core. Operand pairs
// are buffered in a show-ahead entry FIFO and issued under the core's
// ready-for-data handshake. Each issued operation's thread ID is pushed into
// an in-order tag queue and popped when the core returns a result, so the
// core may take any number of cycles per operation as long as it stays in
// order.
//
// Optional feature macro: ADD_WRAP_TAGQ_OUTREG_EN
//   defined     - o_res, o_htId and o_vld are registered (one cycle after op_rdy)
//   not defined - o_res, o_htId and o_vld are combinational from op_rdy
module add_wrap_tagq #(
   parameter int DW           = 64,
   parameter int IDW          = 9,
   parameter int ENTRY_DEPTH  = 32,
   parameter int TAG_DEPTH    = 16,
   parameter int AFULL_MARGIN = 2
) (
   input  logic           ck,
   input  logic           rst,

   input  logic           i_vld,
   input  logic [DW-1:0]  i_a,
   input  logic [DW-1:0]  i_b,
   input  logic           i_sub,
   input  logic [IDW-1:0] i_htId,
   output logic           o_rdy,

   output logic [DW-1:0]  op_a,
   output logic [DW-1:0]  op_b,
   output logic           op_sub,
   output logic           op_nd,
   input  logic           op_rfd,
   input  logic [DW-1:0]  op_res,
   input  logic           op_rdy,

   output logic [DW-1:0]  o_res,
   output logic [IDW-1:0] o_htId,
   output logic           o_vld,
   output logic [1:0]     o_err
);

   localparam int EAW = $clog2(ENTRY_DEPTH);
   localparam int ECW = EAW + 1;
   localparam int TAW = $clog2(TAG_DEPTH);
   localparam int TCW = TAW + 1;
   localparam int EW  = 2 * DW + 1 + IDW;

   localparam logic [ECW-1:0] ENTRY_FULL_CNT  = ECW'(ENTRY_DEPTH);
   localparam logic [ECW-1:0] ENTRY_AFULL_CNT = ECW'(ENTRY_DEPTH - AFULL_MARGIN);
   localparam logic [TCW-1:0] TAG_FULL_CNT    = TCW'(TAG_DEPTH);

   // Entry FIFO storage and bookkeeping
   logic [EW-1:0]  entryMem_q [ENTRY_DEPTH];
   logic [EAW-1:0] entryWrPtr_q, entryWrPtr_d;
   logic [EAW-1:0] entryRdPtr_q, entryRdPtr_d;
   logic [ECW-1:0] entryCnt_q, entryCnt_d;
   logic           rdy_q, rdy_d;

   // Tag queue storage and bookkeeping
   logic [IDW-1:0] tagMem_q [TAG_DEPTH];
   logic [TAW-1:0] tagWrPtr_q, tagWrPtr_d;
   logic [TAW-1:0] tagRdPtr_q, tagRdPtr_d;
   logic [TCW-1:0] tagCnt_q, tagCnt_d;

   // Sticky protocol error flags
   logic [1:0]     err_q, err_d;

   logic           entryEmpty;
   logic           entryFull;
   logic           pushAcc;
   logic           tqEmpty;
   logic           tqFull;
   logic           issue;
   logic           tagPop;
   logic [EW-1:0]  entryHead;
   logic [IDW-1:0] headHtId;
   logic [IDW-1:0] tagHead;
   logic [DW-1:0]  resNext;
   logic [IDW-1:0] htIdNext;

   assign entryEmpty = (entryCnt_q == '0);
   assign entryFull  = (entryCnt_q == ENTRY_FULL_CNT);
   assign pushAcc    = i_vld & ~entryFull;

   // The full test uses the registered count only, so a tag freed in the
   // same cycle cannot be reused until the next one.
   assign tqEmpty    = (tagCnt_q == '0);
   assign tqFull     = (tagCnt_q == TAG_FULL_CNT);

   assign issue      = ~entryEmpty & op_rfd & ~tqFull;
   assign tagPop     = op_rdy & ~tqEmpty;

   // Entry word layout: {sub, htId, b, a}
   assign entryHead  = entryMem_q[entryRdPtr_q];
   assign op_a       = entryHead[DW-1:0];
   assign op_b       = entryHead[2*DW-1:DW];
   assign headHtId   = entryHead[2*DW+IDW-1:2*DW];
   assign op_sub     = entryHead[EW-1];
   assign op_nd      = issue;
   assign o_rdy      = rdy_q;
   assign o_err      = err_q;

   // An empty tag queue reports ID 0 so a stray completion is well defined.
   assign tagHead    = tqEmpty ? '0 : tagMem_q[tagRdPtr_q];

   // Idle cycles present zeros on the result bus.
   assign resNext    = op_rdy ? op_res  : '0;
   assign htIdNext   = op_rdy ? tagHead : '0;

   // Write accepted operand pairs into the entry FIFO storage.
   always_ff @(posedge ck) begin
      if (pushAcc) begin
         entryMem_q[entryWrPtr_q] <= {i_sub, i_htId, i_b, i_a};
      end
   end

   // Entry pointers, occupancy and the look-ahead ready flag.
   always_comb begin
      entryWrPtr_d = entryWrPtr_q;
      entryRdPtr_d = entryRdPtr_q;
      entryCnt_d   = entryCnt_q;
      if (pushAcc) begin
         entryWrPtr_d = entryWrPtr_q + EAW'(1);
      end
      if (issue) begin
         entryRdPtr_d = entryRdPtr_q + EAW'(1);
      end
      case ({pushAcc, issue})
         2'b10:   entryCnt_d = entryCnt_q + ECW'(1);
         2'b01:   entryCnt_d = entryCnt_q - ECW'(1);
         default: entryCnt_d = entryCnt_q;
      endcase
      rdy_d = (entryCnt_d < ENTRY_AFULL_CNT);
   end

   // Register entry FIFO state.
   always_ff @(posedge ck) begin
      if (rst) begin
         entryWrPtr_q <= '0;
         entryRdPtr_q <= '0;
         entryCnt_q   <= '0;
         rdy_q        <= 1'b0;
      end else begin
         entryWrPtr_q <= entryWrPtr_d;
         entryRdPtr_q <= entryRdPtr_d;
         entryCnt_q   <= entryCnt_d;
         rdy_q        <= rdy_d;
      end
   end

   // Record the thread ID of every issued operation in the tag queue.
   always_ff @(posedge ck) begin
      if (issue) begin
         tagMem_q[tagWrPtr_q] <= headHtId;
      end
   end

   // Tag pointers and in-flight count; a completion on an empty queue
   // leaves the count at zero instead of wrapping.
   always_comb begin
      tagWrPtr_d = tagWrPtr_q;
      tagRdPtr_d = tagRdPtr_q;
      tagCnt_d   = tagCnt_q;
      if (issue) begin
         tagWrPtr_d = tagWrPtr_q + TAW'(1);
      end
      if (tagPop) begin
         tagRdPtr_d = tagRdPtr_q + TAW'(1);
      end
      case ({issue, tagPop})
         2'b10:   tagCnt_d = tagCnt_q + TCW'(1);
         2'b01:   tagCnt_d = tagCnt_q - TCW'(1);
         default: tagCnt_d = tagCnt_q;
      endcase
   end

   // Register tag queue state.
   always_ff @(posedge ck) begin
      if (rst) begin
         tagWrPtr_q <= '0;
         tagRdPtr_q <= '0;
         tagCnt_q   <= '0;
      end else begin
         tagWrPtr_q <= tagWrPtr_d;
         tagRdPtr_q <= tagRdPtr_d;
         tagCnt_q   <= tagCnt_d;
      end
   end

   // Accumulate protocol violations: overflow push and orphan completion.
   always_comb begin
      err_d    = err_q;
      err_d[0] = err_q[0] | (i_vld & entryFull);
      err_d[1] = err_q[1] | (op_rdy & tqEmpty);
   end

   // Register the sticky error flags.
   always_ff @(posedge ck) begin
      if (rst) begin
         err_q <= 2'b00;
      end else begin
         err_q <= err_d;
      end
   end

`ifdef ADD_WRAP_TAGQ_OUTREG_EN
   logic [DW-1:0]  res_q;
   logic [IDW-1:0] htId_q;
   logic           vld_q;

   // Retime the completion by one cycle; the tag pop stays in the op_rdy cycle.
   always_ff @(posedge ck) begin
      if (rst) begin
         res_q  <= '0;
         htId_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         res_q  <= resNext;
         htId_q <= htIdNext;
         vld_q  <= op_rdy;
      end
   end

   assign o_res  = res_q;
   assign o_htId = htId_q;
   assign o_vld  = vld_q;
`else
   assign o_res  = resNext;
   assign o_htId = htIdNext;
   assign o_vld  = op_rdy;
`endif

endmodule

// File: tb/tb_add_wrap_tagq.sv
// tb_add_wrap_tagq
// Scoreboard bench for add_wrap_tagq. A behavioural in-order core model with
// selectable latency answers op_nd; expected results (real add/sub of the
// pushed operands plus the thread ID) are queued at push time and a monitor
// compares every o_vld against the queue head.
module tb_add_wrap_tagq;

   localparam int DW  = 64;
   localparam int IDW = 9;
`ifdef ADD_WRAP_TAGQ_OUTREG_EN
   localparam int OUT_LAT = 1;
`else
   localparam int OUT_LAT = 0;
`endif

   typedef struct {
      logic [DW-1:0]  res;
      logic [IDW-1:0] id;
   } exp_t;

   typedef struct {
      logic [DW-1:0] res;
      int            due;
   } core_t;

   logic           ck = 1'b0;
   logic           rst = 1'b1;
   logic           i_vld = 1'b0;
   logic [DW-1:0]  i_a = '0;
   logic [DW-1:0]  i_b = '0;
   logic           i_sub = 1'b0;
   logic [IDW-1:0] i_htId = '0;
   logic           o_rdy;
   logic [DW-1:0]  op_a;
   logic [DW-1:0]  op_b;
   logic           op_sub;
   logic           op_nd;
   logic           op_rfd = 1'b0;
   logic [DW-1:0]  op_res = '0;
   logic           op_rdy = 1'b0;
   logic [DW-1:0]  o_res;
   logic [IDW-1:0] o_htId;
   logic           o_vld;
   logic [1:0]     o_err;

   exp_t           sbQ[$];
   core_t          coreQ[$];
   int             checks = 0;
   int             errors = 0;
   int             cycleCnt = 0;
   int             ndCount = 0;
   int             issueIdx = 0;
   int             lastDue = 0;
   int             latMode = 0;
   int             latFixed = 14;
   bit             coreHold = 1'b0;
   int             injectCnt = 0;
   logic [DW-1:0]  injectVal = '0;
   logic [1:0]     errModel = 2'b00;

   add_wrap_tagq #(
      .DW(DW), .IDW(IDW), .ENTRY_DEPTH(32), .TAG_DEPTH(16), .AFULL_MARGIN(2)
   ) dut (
      .ck(ck), .rst(rst),
      .i_vld(i_vld), .i_a(i_a), .i_b(i_b), .i_sub(i_sub), .i_htId(i_htId),
      .o_rdy(o_rdy),
      .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .op_nd(op_nd),
      .op_rfd(op_rfd), .op_res(op_res), .op_rdy(op_rdy),
      .o_res(o_res), .o_htId(o_htId), .o_vld(o_vld), .o_err(o_err)
   );

   // Free-running clock
   always #5 ck = ~ck;

   // Cycle counter used to schedule core returns and measure latency
   always @(posedge ck) cycleCnt <= cycleCnt + 1;

   // Reference arithmetic: IEEE double add or subtract
   function automatic logic [DW-1:0] refResult(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic sub);
      real ra;
      real rb;
      ra = $bitstoreal(a);
      rb = $bitstoreal(b);
      return sub ? $realtobits(ra - rb) : $realtobits(ra + rb);
   endfunction

   function automatic logic [DW-1:0] randOperand();
      return $realtobits(($itor($urandom_range(0, 2000000)) - 1000000.0) / 64.0);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   // One-cycle push; optionally queues the expected completion
   task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sub,
                                input logic [IDW-1:0] id, input bit record,
                                input logic [DW-1:0] expRes);
      exp_t e;
      i_vld  = 1'b1;
      i_a    = a;
      i_b    = b;
      i_sub  = sub;
      i_htId = id;
      if (record) begin
         e.res = expRes;
         e.id  = id;
         sbQ.push_back(e);
      end
      tick();
      i_vld = 1'b0;
   endtask

   task automatic pushRandom(input logic [IDW-1:0] id, input bit record);
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic          s;
      a = randOperand();
      b = randOperand();
      s = 1'($urandom_range(0, 1));
      applyStimulus(a, b, s, id, record, refResult(a, b, s));
   endtask

   task automatic drain(input int maxCycles);
      for (int k = 0; k < maxCycles; k++) begin
         if (sbQ.size() == 0 && coreQ.size() == 0) break;
         tick();
      end
      tick();
      checks++;
      if (sbQ.size() != 0 || coreQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain_timeout got %0d pending results required 0", sbQ.size());
         sbQ.delete();
         coreQ.delete();
      end
   endtask

   task automatic applyReset(input bit checkIt);
      rst    = 1'b1;
      i_vld  = 1'b0;
      op_rfd = 1'b0;
      tick();
      tick();
      if (checkIt) begin
         checkOutput("reset_o_rdy", 64'(o_rdy), 64'd0);
         checkOutput("reset_o_vld", 64'(o_vld), 64'd0);
         checkOutput("reset_o_res", o_res, 64'd0);
         checkOutput("reset_o_htId", 64'(o_htId), 64'd0);
         checkOutput("reset_op_nd", 64'(op_nd), 64'd0);
         checkOutput("reset_o_err", 64'(o_err), 64'd0);
      end
      coreQ.delete();
      sbQ.delete();
      errModel = 2'b00;
      rst = 1'b0;
      tick();
   endtask

   // Core model, issue side: capture operands on every op_nd
   initial begin
      forever begin
         @(negedge ck);
         if (rst === 1'b0 && op_nd === 1'b1) begin
            core_t c;
            int    lat;
            int    due;
            if (latMode == 0) lat = latFixed;
            else if (latMode == 1) lat = ((issueIdx % 2) == 0) ? 10 : 12;
            else lat = $urandom_range(3, 20);
            due = cycleCnt + lat;
            if (due <= lastDue) due = lastDue + 1;
            lastDue = due;
            issueIdx++;
            ndCount++;
            c.res = refResult(op_a, op_b, op_sub);
            c.due = due;
            coreQ.push_back(c);
         end
      end
   end

   // Core model, return side: results come back in order once due
   initial begin
      forever begin
         @(posedge ck);
         #1;
         op_rdy = 1'b0;
         op_res = '0;
         if (!coreHold && coreQ.size() > 0 && coreQ[0].due <= cycleCnt) begin
            op_rdy = 1'b1;
            op_res = coreQ[0].res;
            void'(coreQ.pop_front());
         end else if (injectCnt > 0) begin
            op_rdy = 1'b1;
            op_res = injectVal;
            injectCnt--;
         end
      end
   end

   // Monitor: every o_vld must match the oldest expected completion
   initial begin
      exp_t e;
      forever begin
         @(negedge ck);
         if (o_vld === 1'b1) begin
            if (sbQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_o_vld got o_vld=1 o_htId=%0d required no result", o_htId);
            end else begin
               e = sbQ.pop_front();
               checkOutput("o_res", o_res, e.res);
               checkOutput("o_htId", 64'(o_htId), 64'(e.id));
            end
         end
      end
   end

   // Watchdog
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int t;
      int ndC;
      int vC;
      int rc;
      int nc;
      int nd0;

      applyReset(1'b1);

      // Single op with a fixed-latency core
      latMode  = 0;
      latFixed = 14;
      op_rfd   = 1'b1;
      t   = cycleCnt;
      ndC = -1;
      vC  = -1;
      applyStimulus(64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 9'd5, 1'b1,
                    64'h4008000000000000);
      for (int k = 0; k < 40; k++) begin
         @(negedge ck);
         if (op_nd === 1'b1 && ndC < 0) ndC = cycleCnt;
         if (o_vld === 1'b1 && vC < 0) vC = cycleCnt;
      end
      #1;
      checkOutput("single_nd_latency", 64'(ndC), 64'(t + 1));
      checkOutput("single_vld_latency", 64'(vC - ndC), 64'(14 + OUT_LAT));
      drain(50);

      // Back-to-back IDs 1..8 through an alternating 10/12 latency core
      latMode  = 1;
      issueIdx = 0;
      for (int i = 1; i <= 8; i++) pushRandom(IDW'(i), 1'b1);
      drain(200);

      // Orphan completion: o_htId=0 and o_err[1], tag count must stay 0
      tick();
      begin
         exp_t e;
         injectVal = randOperand();
         e.res = injectVal;
         e.id  = '0;
         sbQ.push_back(e);
      end
      errModel[1] = 1'b1;
      injectCnt   = 1;
      for (int k = 0; k < 4; k++) tick();
      checkOutput("protocol_o_err", 64'(o_err), 64'(errModel));
      latMode = 0;
      pushRandom(9'd7, 1'b1);
      drain(60);

      // Entry backpressure: no issue, o_rdy tracks occupancy, overflow flagged
      op_rfd = 1'b0;
      for (int i = 0; i < 31; i++) begin
         pushRandom(IDW'(100 + i), 1'b1);
         checkOutput("bp_o_rdy", 64'(o_rdy), 64'((i + 1) < 30));
      end
      pushRandom(9'd200, 1'b1);
      checkOutput("bp_full_o_rdy", 64'(o_rdy), 64'd0);
      pushRandom(9'd201, 1'b0);
      errModel[0] = 1'b1;
      tick();
      checkOutput("bp_o_err", 64'(o_err), 64'(errModel));
      nd0     = ndCount;
      latMode = 2;
      op_rfd  = 1'b1;
      drain(600);
      checkOutput("bp_entry_count", 64'(ndCount - nd0), 64'd32);

      // Tag limit: a stalled core accepts exactly 16 operations
      applyReset(1'b0);
      coreHold = 1'b1;
      latMode  = 0;
      latFixed = 5;
      op_rfd   = 1'b1;
      nd0      = ndCount;
      for (int i = 0; i < 20; i++) pushRandom(IDW'(300 + i), 1'b1);
      for (int k = 0; k < 20; k++) tick();
      checkOutput("tag_limit_issues", 64'(ndCount - nd0), 64'd16);
      coreHold = 1'b0;
      rc = -1;
      nc = -1;
      for (int k = 0; k < 30; k++) begin
         @(negedge ck);
         if (op_rdy === 1'b1 && rc < 0) rc = cycleCnt;
         if (op_nd === 1'b1 && nc < 0) nc = cycleCnt;
      end
      #1;
      checkOutput("tag_reissue_latency", 64'(nc - rc), 64'd1);
      drain(200);
      checkOutput("tag_total_issues", 64'(ndCount - nd0), 64'd20);

      // Reset with five operations in flight
      coreHold = 1'b1;
      for (int i = 0; i < 5; i++) pushRandom(IDW'(400 + i), 1'b1);
      tick();
      tick();
      rst = 1'b1;
      tick();
      checkOutput("midrst_o_vld", 64'(o_vld), 64'd0);
      checkOutput("midrst_o_res", o_res, 64'd0);
      checkOutput("midrst_o_htId", 64'(o_htId), 64'd0);
      checkOutput("midrst_op_nd", 64'(op_nd), 64'd0);
      checkOutput("midrst_o_err", 64'(o_err), 64'd0);
      checkOutput("midrst_o_rdy", 64'(o_rdy), 64'd0);
      sbQ.delete();
      errModel = 2'b00;
      foreach (coreQ[i]) begin
         exp_t e;
         e.res = coreQ[i].res;
         e.id  = '0;
         sbQ.push_back(e);
         errModel[1] = 1'b1;
      end
      rst = 1'b0;
      tick();
      checkOutput("midrst_release_o_rdy", 64'(o_rdy), 64'd1);
      coreHold = 1'b0;
      drain(100);
      checkOutput("midrst_late_o_err", 64'(o_err), 64'(errModel));

      // Randomized traffic against the reference model
      applyReset(1'b0);
      latMode = 2;
      for (int k = 0; k < 600; k++) begin
         op_rfd = ($urandom_range(0, 9) < 7);
         if (o_rdy === 1'b1 && $urandom_range(0, 2) != 0) begin
            pushRandom(IDW'($urandom_range(0, 511)), 1'b1);
         end else begin
            tick();
         end
      end
      op_rfd = 1'b1;
      drain(1500);
      checkOutput("random_o_err", 64'(o_err), 64'(errModel));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
